iohub_tx_scheduler: RTL and testbench

//  Shares the iohub byte-wide UART transmitter between NREQ word sources.

---
 rtl/iohub_tx_scheduler_pkg.sv | 14 +
 rtl/iohub_tx_scheduler_if.sv | 11 +
 rtl/iohub_tx_scheduler_rr_arbiter.sv | 35 +++
 rtl/iohub_tx_scheduler.sv | 129 ++++++++++++
 tb/tb_iohub_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iohub_tx_scheduler_pkg.sv
// Shared definitions for the iohub TX scheduler: state encoding, widths and the sync byte.
package iohub_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [BYTE_W-1:0] TXS_SYNC_BYTE = 8'hA5;

    typedef logic [1:0] txs_state_t;

    localparam txs_state_t IDLE   = 2'd0;
    localparam txs_state_t SEND_S = 2'd1;
    localparam txs_state_t SEND_H = 2'd2;
    localparam txs_state_t SEND_L = 2'd3;
endpackage

// File: rtl/iohub_tx_scheduler_if.sv
// Byte-wide valid/ready link from the scheduler (master) to the UART transmitter (slave).
interface iohub_tx_scheduler_if;
    import iohub_pkg::*;

    logic [BYTE_W-1:0] tx_byte;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_byte, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/iohub_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first pending request after ptr wins, wrapping at NREQ.
module iohub_rr_arbiter
    import iohub_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic             found;
    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/iohub_tx_scheduler.sv
// Shares the UART transmitter between NREQ word sources; each word goes out high byte first.
// Define IOHUB_TXS_SYNC_EN to prefix every frame with the sync byte 8'hA5.
//
// state  | meaning
// IDLE   | no word held; arbitrate, grant and latch a word
// SEND_S | offering the sync byte (only with IOHUB_TXS_SYNC_EN)
// SEND_H | offering word[15:8]
// SEND_L | offering word[7:0]
module iohub_tx_scheduler
    import iohub_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [WORD_W*NREQ-1:0] word_i,
    output logic [NREQ-1:0]        gnt_o,
    iohub_tx_scheduler_if.master   tx_if,
    output logic                   busy_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    txs_state_t        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_sel;
    logic [PTR_W-1:0]  ptr_q;

    logic [NREQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_any;
    logic              load;

    logic [BYTE_W-1:0] tx_byte;
    logic              tx_valid;

    iohub_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign load = (state_q == IDLE) && arb_any;

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) word_sel = word_i[k*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer starts at NREQ-1 so requester 0 is first after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_q <= '0;
            ptr_q  <= PTR_W'(NREQ - 1);
        end else if (load) begin
            word_q <= word_sel;
            ptr_q  <= arb_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef IOHUB_TXS_SYNC_EN
                if (arb_any) state_d = SEND_S;
`else
                if (arb_any) state_d = SEND_H;
`endif
            end
`ifdef IOHUB_TXS_SYNC_EN
            SEND_S: if (tx_if.tx_ready) state_d = SEND_H;
`endif
            SEND_H: if (tx_if.tx_ready) state_d = SEND_L;
            SEND_L: if (tx_if.tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o    = '0;
        tx_valid = 1'b0;
        tx_byte  = '0;
        busy_o   = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (rst_n_i) gnt_o = arb_gnt;
            end
`ifdef IOHUB_TXS_SYNC_EN
            SEND_S: begin
                tx_valid = 1'b1;
                tx_byte  = TXS_SYNC_BYTE;
            end
`endif
            SEND_H: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[15:8];
            end
            SEND_L: begin
                tx_valid = 1'b1;
                tx_byte  = word_q[7:0];
            end
            default: begin
                tx_valid = 1'b0;
                tx_byte  = '0;
            end
        endcase
    end

    assign tx_if.tx_byte  = tx_byte;
    assign tx_if.tx_valid = tx_valid;

endmodule

// File: tb/tb_iohub_tx_scheduler.sv
// Self-checking bench for iohub_tx_scheduler (NREQ=2 and NREQ=4 instances).
module tb_iohub_tx_scheduler;
    import iohub_pkg::*;

`ifdef IOHUB_TXS_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [1:0]  req2  = '0;
    logic [31:0] word2 = '0;
    logic [1:0]  gnt2;
    logic        busy2;
    logic [3:0]  req4  = '0;
    logic [63:0] word4 = '0;
    logic [3:0]  gnt4;
    logic        busy4;

    iohub_tx_scheduler_if if2 ();
    iohub_tx_scheduler_if if4 ();

    iohub_tx_scheduler #(.NREQ(2)) dut2 (
        .clk_i (clk), .rst_n_i (rst_n), .req_i (req2), .word_i (word2),
        .gnt_o (gnt2), .tx_if (if2), .busy_o (busy2)
    );

    iohub_tx_scheduler #(.NREQ(4)) dut4 (
        .clk_i (clk), .rst_n_i (rst_n), .req_i (req4), .word_i (word4),
        .gnt_o (gnt4), .tx_if (if4), .busy_o (busy4)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        ready;
        logic [1:0]  gnt;
        logic        valid;
        logic [7:0]  bval;
    } vec_t;

    vec_t tbl[$];

    task automatic add_idle();
        tbl.push_back('{2'b00, 16'h0, 16'h0, 1'b1, 2'b00, 1'b0, 8'h00});
    endtask

    task automatic add_frame(input logic [1:0] req, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [1:0] gnt, input logic [15:0] word);
        tbl.push_back('{req, w0, w1, 1'b1, gnt, 1'b0, 8'h00});
        if (SYNC != 0) tbl.push_back('{req, w0, w1, 1'b1, 2'b00, 1'b1, TXS_SYNC_BYTE});
        tbl.push_back('{req, w0, w1, 1'b1, 2'b00, 1'b1, word[15:8]});
        tbl.push_back('{req, w0, w1, 1'b1, 2'b00, 1'b1, word[7:0]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req2 = '0; word2 = '0; req4 = '0; word4 = '0;
        if2.tx_ready = 1'b0;
        if4.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: frame byte list per instance, consumed one byte per accepted handshake.
    logic [7:0] mframe[2][3];
    int         mlen[2];
    int         mpos[2];
    int         mptr[2];

    function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
        for (int i = 1; i <= n; i++) begin
            int k;
            k = (ptr + i) % n;
            if (((req >> k) & 8'd1) != 8'd0) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input int id, input int n, input logic [7:0] req,
                              input logic [63:0] words, input logic ready,
                              input logic [7:0] gnt, input logic valid,
                              input logic [7:0] bval, input logic busy);
        int          w;
        logic [15:0] wd;
        if (mpos[id] == mlen[id]) begin
            w = rr_pick(req, mptr[id], n);
            chk("rnd_gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
            chk("rnd_valid", 32'(valid), 32'd0);
            chk("rnd_busy", 32'(busy), 32'd0);
            if (w >= 0) begin
                wd = 16'((words >> (16 * w)) & 64'hFFFF);
                mlen[id] = 0;
                mpos[id] = 0;
                if (SYNC != 0) begin
                    mframe[id][mlen[id]] = TXS_SYNC_BYTE;
                    mlen[id]++;
                end
                mframe[id][mlen[id]] = wd[15:8];
                mframe[id][mlen[id] + 1] = wd[7:0];
                mlen[id] += 2;
                mptr[id] = w;
            end
        end else begin
            chk("rnd_gnt_busy", 32'(gnt), 32'd0);
            chk("rnd_valid", 32'(valid), 32'd1);
            chk("rnd_byte", 32'(bval), 32'(mframe[id][mpos[id]]));
            chk("rnd_busy", 32'(busy), 32'd1);
            if (ready) mpos[id]++;
        end
    endtask

    logic [7:0] stream[$];
    logic [7:0] exp_stream[$];

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt2), 32'd0);
        chk("rst_valid", 32'(if2.tx_valid), 32'd0);
        chk("rst_byte", 32'(if2.tx_byte), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        @(posedge clk); #1;

        // Table: contention alternates, then single word BEEF
        add_idle();
        add_frame(2'b11, 16'h1111, 16'h2222, 2'b01, 16'h1111);
        add_frame(2'b11, 16'h1111, 16'h2222, 2'b10, 16'h2222);
        add_frame(2'b11, 16'h1111, 16'h2222, 2'b01, 16'h1111);
        add_frame(2'b01, 16'hBEEF, 16'h0000, 2'b01, 16'hBEEF);
        add_idle();
        foreach (tbl[i]) begin
            req2 = tbl[i].req;
            word2 = {tbl[i].w1, tbl[i].w0};
            if2.tx_ready = tbl[i].ready;
            @(negedge clk);
            chk("tbl_gnt", 32'(gnt2), 32'(tbl[i].gnt));
            chk("tbl_valid", 32'(if2.tx_valid), 32'(tbl[i].valid));
            chk("tbl_byte", 32'(if2.tx_byte), 32'(tbl[i].bval));
            @(posedge clk); #1;
        end

        // Async reset while in SEND_L
        req2 = 2'b01; word2 = {16'h0000, 16'hCAFE}; if2.tx_ready = 1'b1;
        repeat (2 + SYNC) @(posedge clk);
        #1;
        req2 = 2'b00;
        chk("pre_rst_byte", 32'(if2.tx_byte), 32'h00FE);
        if2.tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if2.tx_valid), 32'd0);
        chk("mid_rst_byte", 32'(if2.tx_byte), 32'd0);
        chk("mid_rst_busy", 32'(busy2), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        req2 = 2'b11; word2 = {16'h7777, 16'h5A3C};
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt2), 32'd1);
        @(posedge clk); #1;
        req2 = 2'b00;

        // Backpressure on the high byte
        if (SYNC != 0) begin
            @(negedge clk);
            chk("bp_sync", 32'(if2.tx_byte), 32'(TXS_SYNC_BYTE));
            if2.tx_ready = 1'b1;
            @(posedge clk); #1;
            if2.tx_ready = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(if2.tx_valid), 32'd1);
            chk("bp_byte", 32'(if2.tx_byte), 32'h005A);
            @(posedge clk); #1;
        end
        if2.tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_hi", 32'(if2.tx_byte), 32'h005A);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_lo", 32'(if2.tx_byte), 32'h003C);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle", 32'(if2.tx_valid), 32'd0);
        @(posedge clk); #1;

        // Byte stream of word 1234 from requester 1 (pointer now at 0)
        req2 = 2'b10; word2 = {16'h1234, 16'h0000};
        if (SYNC != 0) exp_stream.push_back(TXS_SYNC_BYTE);
        exp_stream.push_back(8'h12);
        exp_stream.push_back(8'h34);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("stream_gnt", 32'(gnt2), 32'd2);
            if (if2.tx_valid && if2.tx_ready) stream.push_back(if2.tx_byte);
            @(posedge clk); #1;
            req2 = 2'b00;
        end
        chk("stream_len", 32'(stream.size()), 32'(exp_stream.size()));
        foreach (exp_stream[i]) begin
            chk("stream_byte", (i < stream.size()) ? 32'(stream[i]) : 32'hFFFF_FFFF, 32'(exp_stream[i]));
        end

        // Wrap with NREQ=4: ptr=3 after reset, req 1001 -> 0 then 3
        do_reset();
        req4 = 4'b1001; word4 = {16'h3333, 16'h2222, 16'h1111, 16'h0000}; if4.tx_ready = 1'b1;
        @(negedge clk);
        chk("wrap_gnt0", 32'(gnt4), 32'd1);
        repeat (3 + SYNC) @(posedge clk);
        @(negedge clk);
        chk("wrap_gnt3", 32'(gnt4), 32'd8);
        @(posedge clk); #1;
        req4 = '0;

        // Randomized run against the reference model
        do_reset();
        mlen = '{0, 0}; mpos = '{0, 0}; mptr = '{1, 3};
        for (int c = 0; c < 3000; c++) begin
            req2 = 2'($urandom & $urandom);
            req4 = 4'($urandom & $urandom);
            word2 = $urandom;
            word4 = {$urandom, $urandom};
            if2.tx_ready = ($urandom_range(0, 9) < 6);
            if4.tx_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            model_step(0, 2, 8'(req2), 64'(word2), if2.tx_ready, 8'(gnt2), if2.tx_valid, if2.tx_byte, busy2);
            model_step(1, 4, 8'(req4), word4, if4.tx_ready, 8'(gnt4), if4.tx_valid, if4.tx_byte, busy4);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
